// File: rtl/fc_apb_reg_bridge.sv
// -----------------------------------------------------------------------------
// fc_apb_reg_bridge
//
// APB4 completer that converts every APB transfer into a single valid/ack
// request on a simple register port toward the DUT. Setup-phase addresses
// are checked against the decoded window [BASE_ADDR, BASE_ADDR+WIN_BYTES)
// and against DATA_W/8 alignment. Bad addresses complete with an error and
// no DUT request. A request that is not acknowledged within TIMEOUT cycles
// completes with an error. A transfer abandoned by the requester (psel
// dropped) is counted in abort_cnt. An ack with no request outstanding is
// counted in stray_ack_cnt. Both counters saturate at 255. Every output is
// driven from a register.
//
// DATA_W must be 32 or 64. TIMEOUT must be in 1..65535.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata, pstrb       APB address, write data, write strobes
//   pready, prdata, pslverr    APB completion, read data, error
//   reg_req_valid/wr/addr      register request: valid, write, offset address
//   reg_req_wdata/be           register request: write data, byte enables
//   reg_ack, reg_rdata,        register completion pulse, read data, error
//   reg_err                    (data and error are sampled with reg_ack)
//   stray_ack_cnt              acks seen with no request outstanding
//   abort_cnt                  transfers abandoned while a request was open
// -----------------------------------------------------------------------------
module fc_apb_reg_bridge #(
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 32,
    parameter int unsigned BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WIN_BYTES = 32'h0000_1000,
    parameter int unsigned TIMEOUT   = 32'd256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic                  pready,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pslverr,
    output logic                  reg_req_valid,
    output logic                  reg_req_wr,
    output logic [ADDR_W-1:0]     reg_req_addr,
    output logic [DATA_W-1:0]     reg_req_wdata,
    output logic [DATA_W/8-1:0]   reg_req_be,
    input  logic                  reg_ack,
    input  logic [DATA_W-1:0]     reg_rdata,
    input  logic                  reg_err,
    output logic [7:0]            stray_ack_cnt,
    output logic [7:0]            abort_cnt
);

    localparam int              BE_W     = DATA_W / 8;
    localparam int              ALIGN_W  = $clog2(BE_W);
    localparam logic [ADDR_W:0] BASE_X   = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WIN_X    = (ADDR_W + 1)'(WIN_BYTES);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 32'd1);
    localparam logic [7:0]      CNT_MAX  = 8'hFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_r,     state_s;
    logic [15:0]       tmo_cnt_r,   tmo_cnt_s;
    logic              valid_r,     valid_s;
    logic              wr_r,        wr_s;
    logic [ADDR_W-1:0] addr_r,      addr_s;
    logic [DATA_W-1:0] wdata_r,     wdata_s;
    logic [BE_W-1:0]   be_r,        be_s;
    logic              pready_r,    pready_s;
    logic              pslverr_r,   pslverr_s;
    logic [DATA_W-1:0] prdata_r,    prdata_s;
    logic [7:0]        stray_cnt_r, stray_cnt_s;
    logic [7:0]        abort_cnt_r, abort_cnt_s;

    logic              setup_s;
    logic [ADDR_W:0]   off_s;
    logic              in_win_s;
    logic              aligned_s;

    // Setup-phase address qualification.
    // The offset is computed one bit wider than paddr: an address below the
    // base wraps to a value >= 2^ADDR_W, so one unsigned compare covers both
    // window edges.
    always_comb begin
        setup_s   = psel & ~penable;
        off_s     = {1'b0, paddr} - BASE_X;
        in_win_s  = (off_s < WIN_X);
        aligned_s = (paddr[ALIGN_W-1:0] == {ALIGN_W{1'b0}});
    end

    // Next-state logic for the transfer FSM, request fields, response and counters.
    always_comb begin
        state_s     = state_r;
        tmo_cnt_s   = tmo_cnt_r;
        valid_s     = valid_r;
        wr_s        = wr_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        be_s        = be_r;
        pready_s    = 1'b0;
        pslverr_s   = 1'b0;
        prdata_s    = {DATA_W{1'b0}};
        abort_cnt_s = abort_cnt_r;
        stray_cnt_s = stray_cnt_r;

        // Any ack outside REQ has no request to complete.
        if (reg_ack && (state_r != ST_REQ) && (stray_cnt_r != CNT_MAX)) begin
            stray_cnt_s = stray_cnt_r + 8'd1;
        end else begin
            stray_cnt_s = stray_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (setup_s && !(in_win_s && aligned_s)) begin
                    // Completes in the access cycle: zero wait states.
                    state_s   = ST_ERR;
                    pready_s  = 1'b1;
                    pslverr_s = 1'b1;
                end else if (setup_s) begin
                    state_s   = ST_REQ;
                    valid_s   = 1'b1;
                    tmo_cnt_s = 16'd0;
                    wr_s      = pwrite;
                    addr_s    = off_s[ADDR_W-1:0];
                    wdata_s   = pwdata;
                    be_s      = pwrite ? pstrb : {BE_W{1'b1}};
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (!psel) begin
                    // Requester walked away; no completion is presented.
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    if (abort_cnt_r != CNT_MAX) begin
                        abort_cnt_s = abort_cnt_r + 8'd1;
                    end else begin
                        abort_cnt_s = abort_cnt_r;
                    end
                end else if (reg_ack) begin
                    state_s   = ST_DONE;
                    valid_s   = 1'b0;
                    pready_s  = 1'b1;
                    pslverr_s = reg_err;
                    if (!wr_r && !reg_err) begin
                        prdata_s = reg_rdata;
                    end else begin
                        prdata_s = {DATA_W{1'b0}};
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // Valid has now been high for TIMEOUT cycles.
                    state_s   = ST_DONE;
                    valid_s   = 1'b0;
                    pready_s  = 1'b1;
                    pslverr_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 16'd1;
                end
            end

            ST_ERR: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end

            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, request, response and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= 16'd0;
            valid_r     <= 1'b0;
            wr_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            be_r        <= {BE_W{1'b0}};
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            prdata_r    <= {DATA_W{1'b0}};
            stray_cnt_r <= 8'd0;
            abort_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            tmo_cnt_r   <= tmo_cnt_s;
            valid_r     <= valid_s;
            wr_r        <= wr_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            be_r        <= be_s;
            pready_r    <= pready_s;
            pslverr_r   <= pslverr_s;
            prdata_r    <= prdata_s;
            stray_cnt_r <= stray_cnt_s;
            abort_cnt_r <= abort_cnt_s;
        end
    end

    assign pready        = pready_r;
    assign pslverr       = pslverr_r;
    assign prdata        = prdata_r;
    assign reg_req_valid = valid_r;
    assign reg_req_wr    = wr_r;
    assign reg_req_addr  = addr_r;
    assign reg_req_wdata = wdata_r;
    assign reg_req_be    = be_r;
    assign stray_ack_cnt = stray_cnt_r;
    assign abort_cnt     = abort_cnt_r;

endmodule

// File: tb/tb_fc_apb_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_fc_apb_reg_bridge
//
// Directed bench for fc_apb_reg_bridge. Two instances: "dut" with the default
// TIMEOUT of 256, and "dut_t" with TIMEOUT=4 for the timeout scenario. Only
// the instance selected by sel4 sees psel. A cycle-level reference model of
// the main instance is checked against it on every falling edge; directed
// scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fc_apb_reg_bridge;

    localparam int TMO_MAIN = 256;
    localparam int WIN      = 32'h1000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, sel4 = 1'b0;
    logic [15:0] paddr  = 16'h0;
    logic [31:0] pwdata = 32'h0;
    logic [3:0]  pstrb  = 4'h0;
    logic        psel_m, psel_4;

    // main instance
    logic        pready, pslverr, reg_req_valid, reg_req_wr;
    logic [31:0] prdata, reg_req_wdata;
    logic [15:0] reg_req_addr;
    logic [3:0]  reg_req_be;
    logic [7:0]  stray_ack_cnt, abort_cnt;
    logic        reg_ack;
    logic        resp_ack = 1'b0, man_ack = 1'b0, reg_err = 1'b0;
    logic [31:0] reg_rdata = 32'h0;

    // TIMEOUT=4 instance
    logic        pready_t, pslverr_t, valid_t, wr_t;
    logic [31:0] prdata_t, wdata_t;
    logic [15:0] addr_t;
    logic [3:0]  be_t;
    logic [7:0]  stray_t, abort_t;
    logic        ack_t = 1'b0, err_t = 1'b0;
    logic [31:0] rdata_t = 32'h0;

    // outputs of whichever instance is currently addressed
    logic        pready_x, pslverr_x, valid_x;
    logic [31:0] prdata_x, wdata_x;
    logic [15:0] addr_x;
    logic [3:0]  be_x;

    assign psel_m    = psel & ~sel4;
    assign psel_4    = psel & sel4;
    assign reg_ack   = resp_ack | man_ack;
    assign pready_x  = sel4 ? pready_t  : pready;
    assign pslverr_x = sel4 ? pslverr_t : pslverr;
    assign prdata_x  = sel4 ? prdata_t  : prdata;
    assign valid_x   = sel4 ? valid_t   : reg_req_valid;
    assign addr_x    = sel4 ? addr_t    : reg_req_addr;
    assign be_x      = sel4 ? be_t      : reg_req_be;
    assign wdata_x   = sel4 ? wdata_t   : reg_req_wdata;

    fc_apb_reg_bridge #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(32'h0), .WIN_BYTES(32'h1000),
                        .TIMEOUT(32'd256)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel_m), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .reg_req_valid(reg_req_valid), .reg_req_wr(reg_req_wr),
        .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata), .reg_req_be(reg_req_be),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
        .stray_ack_cnt(stray_ack_cnt), .abort_cnt(abort_cnt));

    fc_apb_reg_bridge #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(32'h0), .WIN_BYTES(32'h1000),
                        .TIMEOUT(32'd4)) dut_t (
        .clk(clk), .rst_n(rst_n), .psel(psel_4), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_t), .prdata(prdata_t),
        .pslverr(pslverr_t), .reg_req_valid(valid_t), .reg_req_wr(wr_t),
        .reg_req_addr(addr_t), .reg_req_wdata(wdata_t), .reg_req_be(be_t),
        .reg_ack(ack_t), .reg_rdata(rdata_t), .reg_err(err_t),
        .stray_ack_cnt(stray_t), .abort_cnt(abort_t));

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register-side responder for the main instance --------
    int          ack_delay = 0;
    logic [31:0] rsp_data  = 32'h0;
    logic        rsp_err   = 1'b0;
    int          vcnt      = 0;

    initial forever begin
        @(negedge clk);
        resp_ack = 1'b0;
        if (rst_n && reg_req_valid) begin
            if (vcnt == ack_delay) begin
                resp_ack  = 1'b1;
                reg_rdata = rsp_data;
                reg_err   = rsp_err;
            end
            vcnt++;
        end else begin
            vcnt = 0;
        end
    end

    // ---------------- reference model of the main instance -----------------
    // m_active : a register request is outstanding (valid expected high)
    // m_age    : number of cycles that request has already been visible
    // m_rsp    : an APB completion is presented this cycle
    bit          m_active = 1'b0, m_rsp = 1'b0, m_rsp_err = 1'b0, m_wr = 1'b0;
    int          m_age = 0, m_stray = 0, m_abort = 0;
    logic [31:0] m_rsp_data = 32'h0, m_wdata = 32'h0;
    logic [15:0] m_addr = 16'h0;
    logic [3:0]  m_be = 4'h0;
    bit          n_rsp, n_err;
    logic [31:0] n_data;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 1'b0; m_rsp = 1'b0; m_rsp_err = 1'b0; m_rsp_data = 32'h0;
            m_age = 0; m_stray = 0; m_abort = 0;
        end else begin
            n_rsp = 1'b0; n_err = 1'b0; n_data = 32'h0;
            if (reg_ack && !m_active && m_stray < 255) m_stray++;
            if (m_active) begin
                if (!psel_m) begin
                    m_active = 1'b0;
                    if (m_abort < 255) m_abort++;
                end else if (reg_ack) begin
                    m_active = 1'b0; n_rsp = 1'b1; n_err = reg_err;
                    n_data = (!m_wr && !reg_err) ? reg_rdata : 32'h0;
                end else if (m_age + 1 >= TMO_MAIN) begin
                    m_active = 1'b0; n_rsp = 1'b1; n_err = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (!m_rsp && psel_m && !penable) begin
                if (int'(paddr) >= WIN || (paddr % 16'd4) != 16'd0) begin
                    n_rsp = 1'b1; n_err = 1'b1;
                end else begin
                    m_active = 1'b1; m_age = 0; m_wr = pwrite; m_addr = paddr;
                    m_wdata = pwdata; m_be = pwrite ? pstrb : 4'hF;
                end
            end
            m_rsp = n_rsp; m_rsp_err = n_err; m_rsp_data = n_data;
        end
    end

    // ---------------- per-cycle compare of main instance vs model ----------
    initial forever begin
        @(negedge clk);
        check("m_pready", 64'(pready), 64'(m_rsp));
        if (m_rsp) check("m_pslverr", 64'(pslverr), 64'(m_rsp_err));
        check("m_prdata", 64'(prdata), 64'(m_rsp ? m_rsp_data : 32'h0));
        check("m_valid", 64'(reg_req_valid), 64'(m_active));
        if (m_active) begin
            check("m_wr", 64'(reg_req_wr), 64'(m_wr));
            check("m_addr", 64'(reg_req_addr), 64'(m_addr));
            check("m_wdata", 64'(reg_req_wdata), 64'(m_wdata));
            check("m_be", 64'(reg_req_be), 64'(m_be));
        end
        check("m_stray", 64'(stray_ack_cnt), 64'(m_stray));
        check("m_abort", 64'(abort_cnt), 64'(m_abort));
    end

    // ---------------- APB master ------------------------------------------
    // Called at a falling edge; returns at the falling edge one cycle after
    // the completion, with the bus idle, so a following call is back-to-back.
    task automatic xfer(input logic t4, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int waits, output int vcyc, output logic [31:0] rd,
                        output logic err, output logic [15:0] qa, output logic [3:0] qb,
                        output logic [31:0] qd);
        sel4 = t4; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        waits = 0; vcyc = 0; rd = 32'h0; err = 1'b0; qa = 16'h0; qb = 4'h0; qd = 32'h0;
        while (pready_x !== 1'b1 && waits < 400) begin
            if (valid_x === 1'b1) begin
                vcyc++; qa = addr_x; qb = be_x; qd = wdata_x;
            end
            @(negedge clk);
            waits++;
        end
        check("xfer_completed", 64'(pready_x), 64'h1);
        rd  = prdata_x;
        err = pslverr_x;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    int          w, v;
    logic [31:0] rd, qd;
    logic        er;
    logic [15:0] qa;
    logic [3:0]  qb;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pready",  64'(pready), 64'h0);
        check("rst_pslverr", 64'(pslverr), 64'h0);
        check("rst_prdata",  64'(prdata), 64'h0);
        check("rst_valid",   64'(reg_req_valid), 64'h0);
        check("rst_fields",  64'({reg_req_wr, reg_req_addr, reg_req_wdata, reg_req_be}), 64'h0);
        check("rst_cnts",    64'({stray_ack_cnt, abort_cnt}), 64'h0);
        check("rst_t_all",   64'({pready_t, pslverr_t, valid_t, stray_t, abort_t}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // write, ack on the first valid cycle
        ack_delay = 0; rsp_err = 1'b0; rsp_data = 32'h0;
        xfer(1'b0, 1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF, w, v, rd, er, qa, qb, qd);
        check("t1_waits", 64'(w), 64'd1);
        check("t1_vcyc",  64'(v), 64'd1);
        check("t1_addr",  64'(qa), 64'h10);
        check("t1_be",    64'(qb), 64'hF);
        check("t1_wdata", 64'(qd), 64'hA5A5_5A5A);
        check("t1_err",   64'(er), 64'h0);

        // back-to-back read at the top of the window, ack on the 6th valid cycle
        ack_delay = 5; rsp_data = 32'h1234_5678;
        xfer(1'b0, 1'b0, 16'h0FFC, 32'h0, 4'h0, w, v, rd, er, qa, qb, qd);
        check("t2_waits", 64'(w), 64'd6);
        check("t2_vcyc",  64'(v), 64'd6);
        check("t2_rdata", 64'(rd), 64'h1234_5678);
        check("t2_err",   64'(er), 64'h0);
        check("t2_addr",  64'(qa), 64'hFFC);
        check("t2_be",    64'(qb), 64'hF);

        // out of window and misaligned: error in the access cycle, no request
        ack_delay = 0;
        xfer(1'b0, 1'b0, 16'h1000, 32'h0, 4'h0, w, v, rd, er, qa, qb, qd);
        check("t3a_waits", 64'(w), 64'd0);
        check("t3a_vcyc",  64'(v), 64'd0);
        check("t3a_err",   64'(er), 64'h1);
        check("t3a_rdata", 64'(rd), 64'h0);
        xfer(1'b0, 1'b0, 16'h0002, 32'h0, 4'h0, w, v, rd, er, qa, qb, qd);
        check("t3b_waits", 64'(w), 64'd0);
        check("t3b_vcyc",  64'(v), 64'd0);
        check("t3b_err",   64'(er), 64'h1);

        // DUT-reported error on a read: pslverr set, prdata forced to zero
        ack_delay = 2; rsp_data = 32'hDEAD_BEEF; rsp_err = 1'b1;
        xfer(1'b0, 1'b0, 16'h0100, 32'h0, 4'h0, w, v, rd, er, qa, qb, qd);
        check("te_waits", 64'(w), 64'd3);
        check("te_err",   64'(er), 64'h1);
        check("te_rdata", 64'(rd), 64'h0);

        // write with no strobes is still forwarded
        ack_delay = 0; rsp_err = 1'b0;
        xfer(1'b0, 1'b1, 16'h0200, 32'h0BAD_F00D, 4'h0, w, v, rd, er, qa, qb, qd);
        check("ts_vcyc",  64'(v), 64'd1);
        check("ts_be",    64'(qb), 64'h0);
        check("ts_wdata", 64'(qd), 64'h0BAD_F00D);
        check("ts_err",   64'(er), 64'h0);

        // timeout on the TIMEOUT=4 instance, then a late ack
        xfer(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, w, v, rd, er, qa, qb, qd);
        check("t4_vcyc",  64'(v), 64'd4);
        check("t4_waits", 64'(w), 64'd4);
        check("t4_err",   64'(er), 64'h1);
        check("t4_rdata", 64'(rd), 64'h0);
        check("t4_addr",  64'(qa), 64'h20);
        repeat (2) @(negedge clk);
        ack_t = 1'b1;
        @(negedge clk);
        ack_t = 1'b0;
        @(negedge clk);
        check("t4_stray", 64'(stray_t), 64'd1);
        check("t4_abort", 64'(abort_t), 64'd0);
        sel4 = 1'b0;

        // abort: psel dropped in the 2nd request cycle
        ack_delay = 1000;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040; pwdata = 32'h5555_AAAA; pstrb = 4'h3;
        @(negedge clk);
        penable = 1'b1;
        check("t5_valid1", 64'(reg_req_valid), 64'h1);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        check("t5_valid2", 64'(reg_req_valid), 64'h1);
        @(negedge clk);
        check("t5_valid_drop", 64'(reg_req_valid), 64'h0);
        check("t5_abort",      64'(abort_cnt), 64'd1);
        ack_delay = 0;
        xfer(1'b0, 1'b1, 16'h0044, 32'h0102_0304, 4'hF, w, v, rd, er, qa, qb, qd);
        check("t5n_waits", 64'(w), 64'd1);
        check("t5n_err",   64'(er), 64'h0);
        check("t5n_abort", 64'(abort_cnt), 64'd1);

        // asynchronous reset in the middle of a request
        ack_delay = 1000;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0080; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check("t6_inflight", 64'(reg_req_valid), 64'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(reg_req_valid), 64'h0);
        check("t6_rst_ready", 64'({pready, pslverr, prdata}), 64'h0);
        check("t6_rst_cnts",  64'({stray_ack_cnt, abort_cnt}), 64'h0);
        check("t6_rst_flds",  64'({reg_req_wr, reg_req_addr, reg_req_be}), 64'h0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            man_ack = 1'b1;
            @(negedge clk);
            man_ack = 1'b0;
            @(negedge clk);
        end
        check("t6_stray_sat", 64'(stray_ack_cnt), 64'd255);
        check("t6_abort",     64'(abort_cnt), 64'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
